// File: rtl/cc_seq_pkg.sv
// cc_seq_pkg: shared types and width helpers for the cc_seq frame sorter/evaluator.
// Contents: FSM state enum, in_opt bit indices, element/norm/product width functions.
package cc_seq_pkg;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SORT, S_NORM, S_EQ, S_OUT} state_t;

    localparam int OPT_SGN  = 0;
    localparam int OPT_DESC = 1;
    localparam int OPT_AVG  = 2;

    function automatic int elem_w(int dw);
        return dw + 1;
    endfunction

    function automatic int norm_w(int dw);
        return dw + 2;
    endfunction

    function automatic int prod_w(int dw);
        return 2 * (dw + 2) + 3;
    endfunction

endpackage

// File: rtl/cc_cmp_swap.sv
// cc_cmp_swap: one signed compare-exchange unit.
// Ports: a, b   - operands (W-bit two's complement)
//        desc   - 1: larger value goes to lo, 0: smaller value goes to lo
//        lo, hi - ordered outputs for the lower / higher element index
module cc_cmp_swap #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         desc,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic swap;

    always_comb begin
        swap = desc ? ($signed(a) < $signed(b)) : ($signed(a) > $signed(b));
        lo   = swap ? b : a;
        hi   = swap ? a : b;
    end

endmodule

// File: rtl/cc_seq.sv
// cc_seq: sequential frame sorter, normaliser and equation evaluator.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_data with in_opt/in_equ
//        sampled on the first element; out_valid/out_ready/out_n result; busy = not IDLE.
// Config: define CC_SEQ_SAT_EN to saturate the result to OUT_W bits, else it wraps.
module cc_seq
    import cc_seq_pkg::*;
#(
    parameter int NUM   = 6,
    parameter int DW    = 4,
    parameter int OUT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic [2:0]       in_opt,
    input  logic             in_equ,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_n,
    output logic             busy
);

    localparam int EW   = elem_w(DW);
    localparam int NW   = norm_w(DW);
    localparam int PW   = prod_w(DW);
    localparam int CW   = $clog2(NUM);
    localparam int NH   = NUM / 2;
    localparam int MAXV = 2 ** (OUT_W - 1) - 1;
    localparam int MINV = -(2 ** (OUT_W - 1));

    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0] opt;
    logic equ, acc, last, sgn;
    logic signed [EW-1:0] s [NUM];
    logic signed [EW-1:0] s_nx [NUM];
    logic [EW-1:0] lo [NH];
    logic [EW-1:0] hi [NH];
    logic signed [NW-1:0] nrm [NUM];
    logic signed [EW-1:0] elem, s0, sk;
    logic signed [NW-1:0] n0, prev, nk;
    logic signed [NW+1:0] ma_sum, ma_q;
    logic signed [PW-1:0] d1, p1, p0, full, prod;
    logic [OUT_W-1:0] res;

    assign acc  = in_valid && in_ready;
    assign last = cnt == CW'(NUM - 1);
    // Sign mode comes straight from the port on the first element, before it is latched.
    assign sgn  = (state == S_IDLE) ? in_opt[OPT_SGN] : opt[OPT_SGN];
    assign elem = sgn ? {in_data[DW-1], in_data} : {1'b0, in_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = state != S_IDLE;
        case (state)
            S_IDLE:  if (acc) state_n = S_LOAD;
            S_LOAD:  if (acc && last) state_n = S_SORT;
            S_SORT:  if (last) state_n = S_NORM;
            S_NORM:  if (last) state_n = S_EQ;
            S_EQ:    state_n = S_OUT;
            S_OUT:   if (out_valid && out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Units are shared between passes: even passes order (2i,2i+1), odd passes (2i+1,2i+2).
    for (genvar i = 0; i < NH; i++) begin : g_cs
        localparam int B = (2 * i + 2) % NUM;
        cc_cmp_swap #(.W(EW)) u_cs (
            .a   (cnt[0] ? s[2*i+1] : s[2*i]),
            .b   (cnt[0] ? s[B] : s[2*i+1]),
            .desc(opt[OPT_DESC]),
            .lo  (lo[i]),
            .hi  (hi[i])
        );
    end

    always_comb begin
        s_nx = s;
        for (int i = 0; i < NH; i++) begin
            if (!cnt[0]) begin
                s_nx[2*i]   = lo[i];
                s_nx[2*i+1] = hi[i];
            end else if (2 * i + 2 < NUM) begin
                s_nx[2*i+1]             = lo[i];
                s_nx[(2*i+2) % NUM]     = hi[i];
            end
        end
    end

    always_comb begin
        s0     = s[0];
        sk     = s[cnt];
        n0     = opt[OPT_AVG] ? NW'(s0) : '0;
        prev   = (cnt == CW'(1)) ? n0 : nrm[cnt - CW'(1)];
        ma_sum = ((NW+2)'(prev) <<< 1) + (NW+2)'(sk);
        ma_q   = ma_sum / (NW+2)'(3);
        nk     = opt[OPT_AVG] ? NW'(ma_q) : NW'(sk) - NW'(s0);
    end

    always_comb begin
        d1   = PW'(nrm[1]) - PW'(nrm[0]);
        p1   = d1 * PW'(nrm[NUM-1]);
        p0   = ((PW'(nrm[3]) + (PW'(nrm[4]) <<< 2)) * PW'(nrm[NUM-1])) / PW'(3);
        full = equ ? (p1[PW-1] ? -p1 : p1) : p0;
`ifdef CC_SEQ_SAT_EN
        res  = (int'(prod) > MAXV) ? OUT_W'(MAXV) : (int'(prod) < MINV) ? OUT_W'(MINV) : OUT_W'(prod);
`else
        res  = OUT_W'(prod);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            opt       <= '0;
            equ       <= 1'b0;
            prod      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_n     <= '0;
            for (int i = 0; i < NUM; i++) begin
                s[i]   <= '0;
                nrm[i] <= '0;
            end
        end else begin
            in_ready <= state_n == S_IDLE || state_n == S_LOAD;
            case (state)
                S_IDLE: if (acc) begin
                    s[0] <= elem;
                    opt  <= in_opt;
                    equ  <= in_equ;
                    cnt  <= CW'(1);
                end
                S_LOAD: if (acc) begin
                    s[cnt] <= elem;
                    cnt    <= last ? '0 : cnt + CW'(1);
                end
                S_SORT: begin
                    s   <= s_nx;
                    cnt <= last ? CW'(1) : cnt + CW'(1);
                end
                S_NORM: begin
                    nrm[cnt] <= nk;
                    if (cnt == CW'(1)) nrm[0] <= n0;
                    cnt <= last ? '0 : cnt + CW'(1);
                end
                S_EQ: prod <= full;
                S_OUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_n     <= res;
                    end else if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cc_seq.sv
// tb_cc_seq: scoreboard bench for cc_seq, one default instance and one with OUT_W=8.
module tb_cc_seq;

    localparam int NUM = 6;
    localparam int DW  = 4;

    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, in_equ = 0;
    logic [DW-1:0] in_data = '0;
    logic [2:0] in_opt = '0;
    logic in_ready, out_valid, busy, in_ready8, out_valid8, busy8;
    logic [9:0] out_n;
    logic [7:0] out_n8;
    int checks = 0, errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    cc_seq #(.NUM(NUM), .DW(DW), .OUT_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_opt(in_opt), .in_equ(in_equ), .out_valid(out_valid), .out_ready(out_ready),
        .out_n(out_n), .busy(busy));

    cc_seq #(.NUM(NUM), .DW(DW), .OUT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
        .in_opt(in_opt), .in_equ(in_equ), .out_valid(out_valid8), .out_ready(out_ready),
        .out_n(out_n8), .busy(busy8));

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic int model(input int f[NUM], input logic [2:0] o, input logic e);
        int s[NUM];
        int n[NUM];
        int t;
        for (int i = 0; i < NUM; i++) s[i] = (o[0] && f[i] >= 8) ? f[i] - 16 : f[i];
        for (int i = 0; i < NUM; i++)
            for (int j = 0; j < NUM - 1 - i; j++)
                if (o[1] ? s[j] < s[j+1] : s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        n[0] = o[2] ? s[0] : 0;
        for (int k = 1; k < NUM; k++) n[k] = o[2] ? (2 * n[k-1] + s[k]) / 3 : s[k] - s[0];
        if (e) begin
            t = (n[1] - n[0]) * n[NUM-1];
            return t < 0 ? -t : t;
        end
        return ((n[3] + 4 * n[4]) * n[NUM-1]) / 3;
    endfunction

    function automatic int red(input int v, input int w);
        int lim;
        int r;
        lim = 1 << (w - 1);
`ifdef CC_SEQ_SAT_EN
        r = v > lim - 1 ? lim - 1 : v < -lim ? -lim : v;
`else
        r = v & ((1 << w) - 1);
        r = r >= lim ? r - (1 << w) : r;
`endif
        return r;
    endfunction

    task automatic send_frame(input int f[NUM], input logic [2:0] o, input logic e, input bit gaps, input bit keep);
        int w;
        exp_q.push_back(model(f, o, e));
        for (int i = 0; i < NUM; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 0;
                @(negedge clk);
            end
            in_valid = 1;
            in_data  = DW'(f[i]);
            in_opt   = (i == 0) ? o : 3'($urandom);
            in_equ   = (i == 0) ? e : 1'($urandom);
            w = 0;
            while (!in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w == 50) check("in_ready_timeout", 0, 1);
            @(negedge clk);
        end
        if (keep) begin
            in_data = '1;
            in_opt  = '1;
        end else in_valid = 0;
    endtask

    task automatic collect(input int hold);
        int lat, first, want;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 2 * NUM + 1);
        if (exp_q.size() == 0) check("queue_empty", 0, 1);
        else begin
            want = exp_q.pop_front();
            check("out_n", int'($signed(out_n)), red(want, 10));
            check("out_n8", int'($signed(out_n8)), red(want, 8));
        end
        first = int'($signed(out_n));
        for (int h = 0; h < hold; h++) begin
            check("hold_in_ready", int'(in_ready), 0);
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_stable", int'($signed(out_n)), first);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check("valid_drop", int'(out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int f1[NUM], f3[NUM], f4[NUM], fr[NUM];
        f1 = '{3, 1, 4, 1, 5, 9};
        f3 = '{8, 7, 0, 15, 2, 3};
        f4 = '{0, 15, 15, 15, 15, 15};
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_n", int'(out_n), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);

        send_frame(f1, 3'b000, 1'b0, 0, 0);
        collect(0);
        send_frame(f1, 3'b010, 1'b1, 0, 0);
        collect(0);
        send_frame(f3, 3'b101, 1'b1, 0, 0);
        collect(0);
        send_frame(f4, 3'b000, 1'b0, 0, 0);
        collect(0);

        send_frame(f1, 3'b000, 1'b0, 0, 1);
        collect(5);
        check("next_in_ready", int'(in_ready), 1);
        send_frame(f1, 3'b010, 1'b1, 0, 0);
        collect(0);

        send_frame(f3, 3'b101, 1'b0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_out_n", int'(out_n), 0);
        check("abort_in_ready", int'(in_ready), 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        send_frame(f1, 3'b000, 1'b0, 0, 0);
        collect(0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NUM; i++) fr[i] = $urandom_range(0, 15);
            send_frame(fr, 3'($urandom), 1'($urandom), 1, 0);
            collect($urandom_range(0, 2));
        end

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
